npu_param_loader: RTL and testbench

NPU_PARAM_LOADER -- requirements
Module: npu_param_loader

---
 rtl/npu_param_loader.sv | 202 ++++++++++++++++++++
 tb/tb_npu_param_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/npu_param_loader.sv
// npu_param_loader: streams a full NPU parameter set (weights, then biases) into packed output registers.
// Latency: params_valid rises one cycle after the last accepted word. Optional XOR checksum word when NPU_PARAM_LOADER_CKSUM_EN is defined.
// Backpressure: s_ready is high whenever a load is in progress; s_valid=0 stalls the load indefinitely.
//
// Ports:
//   clk, rst_n            - system clock, asynchronous active-low reset
//   start                 - request a new load (honoured only while idle)
//   s_data/s_valid/s_ready - parameter word stream (valid/ready handshake)
//   weights_flat          - WEIGHT_WORDS packed words, first streamed word at the LSBs
//   biases_flat           - BIAS_WORDS packed words, first bias word at the LSBs
//   params_valid          - complete (and, with checksum, verified) set present
//   busy                  - load in progress
//   cksum_err             - last load failed its checksum (always 0 without the checksum option)
module npu_param_loader #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WORDS = 64,
    parameter int BIAS_WORDS   = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [DATA_WIDTH-1:0]              s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [WEIGHT_WORDS*DATA_WIDTH-1:0] weights_flat,
    output logic [BIAS_WORDS*DATA_WIDTH-1:0]   biases_flat,
    output logic                               params_valid,
    output logic                               busy,
    output logic                               cksum_err
);

    localparam int MAX_WORDS = (WEIGHT_WORDS > BIAS_WORDS) ? WEIGHT_WORDS : BIAS_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WEIGHT_WORDS - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BIAS_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_B = 2'd2
`ifdef NPU_PARAM_LOADER_CKSUM_EN
        ,
        CKSUM  = 2'd3
`endif
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [CNT_W-1:0]                     r_cnt;
    logic [WEIGHT_WORDS*DATA_WIDTH-1:0]   r_weights;
    logic [BIAS_WORDS*DATA_WIDTH-1:0]     r_biases;
    logic                                 r_params_valid;
    logic                                 w_xfer;

`ifdef NPU_PARAM_LOADER_CKSUM_EN
    logic [DATA_WIDTH-1:0]                r_cksum;
    logic                                 r_cksum_err;
`endif

    assign w_xfer = s_valid & s_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_xfer && (r_cnt == W_LAST)) begin
                    w_state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_xfer && (r_cnt == B_LAST)) begin
`ifdef NPU_PARAM_LOADER_CKSUM_EN
                    w_state_nxt = CKSUM;
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef NPU_PARAM_LOADER_CKSUM_EN
            CKSUM: begin
                if (w_xfer) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Not ready in IDLE, so the start cycle can never also carry a transfer.
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        if (r_state != IDLE) begin
            s_ready = 1'b1;
            busy    = 1'b1;
        end
    end

    // ---------------- datapath ----------------
    // Each transfer writes only the slot selected by the counter; all other
    // words keep the value from the previous load until they are overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_weights      <= '0;
            r_biases       <= '0;
            r_params_valid <= 1'b0;
`ifdef NPU_PARAM_LOADER_CKSUM_EN
            r_cksum        <= '0;
            r_cksum_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt          <= '0;
                        r_params_valid <= 1'b0;
`ifdef NPU_PARAM_LOADER_CKSUM_EN
                        r_cksum        <= '0;
                        r_cksum_err    <= 1'b0;
`endif
                    end
                end
                LOAD_W: begin
                    if (w_xfer) begin
                        for (int k = 0; k < WEIGHT_WORDS; k++) begin
                            if (r_cnt == CNT_W'(k)) begin
                                r_weights[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            end
                        end
`ifdef NPU_PARAM_LOADER_CKSUM_EN
                        r_cksum <= r_cksum ^ s_data;
`endif
                        r_cnt <= (r_cnt == W_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (w_xfer) begin
                        for (int k = 0; k < BIAS_WORDS; k++) begin
                            if (r_cnt == CNT_W'(k)) begin
                                r_biases[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            end
                        end
`ifdef NPU_PARAM_LOADER_CKSUM_EN
                        r_cksum <= r_cksum ^ s_data;
`endif
                        if (r_cnt == B_LAST) begin
                            r_cnt <= '0;
`ifndef NPU_PARAM_LOADER_CKSUM_EN
                            r_params_valid <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef NPU_PARAM_LOADER_CKSUM_EN
                CKSUM: begin
                    // r_cksum already holds the XOR of every weight and bias word.
                    if (w_xfer) begin
                        if (s_data == r_cksum) begin
                            r_params_valid <= 1'b1;
                        end else begin
                            r_cksum_err <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign weights_flat = r_weights;
    assign biases_flat  = r_biases;
    assign params_valid = r_params_valid;
`ifdef NPU_PARAM_LOADER_CKSUM_EN
    assign cksum_err    = r_cksum_err;
`else
    assign cksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_npu_param_loader.sv
// tb_npu_param_loader: directed self-checking bench for npu_param_loader (default parameters).
// Drives inputs 1 time unit after the rising edge and samples there too.
// Expected contents and cycle counts are computed by the bench from the stimulus.
module tb_npu_param_loader;

    localparam int DW = 8;
    localparam int WW = 64;
    localparam int BW = 12;
`ifdef NPU_PARAM_LOADER_CKSUM_EN
    localparam int NW = WW + BW + 1;
`else
    localparam int NW = WW + BW;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DW-1:0]    s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WW*DW-1:0] weights_flat;
    logic [BW*DW-1:0] biases_flat;
    logic             params_valid;
    logic             busy;
    logic             cksum_err;

    int n_cmp = 0;
    int n_bad = 0;
    int edges;

    npu_param_loader #(
        .DATA_WIDTH   (DW),
        .WEIGHT_WORDS (WW),
        .BIAS_WORDS   (BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .weights_flat (weights_flat),
        .biases_flat  (biases_flat),
        .params_valid (params_valid),
        .busy         (busy),
        .cksum_err    (cksum_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW*DW-1:0] exp_w(input logic [7:0] base);
        logic [WW*DW-1:0] r;
        r = '0;
        for (int k = 0; k < WW; k++) r[k*DW +: DW] = 8'(base + k + 1);
        return r;
    endfunction

    function automatic logic [BW*DW-1:0] exp_b(input logic [7:0] base);
        logic [BW*DW-1:0] r;
        r = '0;
        for (int k = 0; k < BW; k++) r[k*DW +: DW] = 8'(base + WW + k + 1);
        return r;
    endfunction

    function automatic logic [7:0] ck_of(input logic [7:0] base);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < WW + BW; k++) c = c ^ 8'(base + k + 1);
        return c;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 512'(s_ready), 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_params_valid"}, 512'(params_valid), 512'(0));
        check({tag, "_cksum_err"}, 512'(cksum_err), 512'(0));
        check({tag, "_weights"}, 512'(weights_flat), 512'(0));
        check({tag, "_biases"}, 512'(biases_flat), 512'(0));
    endtask

    // One load: start pulse, then NW words. Word k (k<76) is base+k+1, or 1 when 'ones';
    // the optional checksum word is ck_word. 'edges' counts rising edges from the start edge.
    task automatic do_load(input logic [7:0] base, input bit ones, input bit toggle,
                           input int start_at, input int abort_at, input logic [7:0] retain_exp,
                           input logic [7:0] ck_word, output int n_edges);
        int  word;
        int  phase;
        bit  xfer;
        start   = 1'b1;
        n_edges = 0;
        @(posedge clk); #1;
        n_edges++;
        start = 1'b0;
        word  = 0;
        phase = 0;
        while (word < NW && n_edges < 2000) begin
            if (word == abort_at) begin
                check("abort_pre_pv", 512'(params_valid), 512'(0));
                check("abort_pre_busy", 512'(busy), 512'(1));
                check("abort_retain_w63", 512'(weights_flat[63*DW +: DW]), 512'(retain_exp));
                check("abort_new_w0", 512'(weights_flat[DW-1:0]), 512'(8'(base + 1)));
                s_valid = 1'b0;
                rst_n   = 1'b0;
                #1;
                check_all_zero("abort_rst");
                #1;
                rst_n = 1'b1;
                return;
            end
            if (word == start_at) start = 1'b1;
            s_valid = !(toggle && phase[0]);
            s_data  = (word < WW + BW) ? (ones ? 8'h01 : 8'(base + word + 1)) : ck_word;
            xfer    = s_valid && s_ready;
            @(posedge clk); #1;
            n_edges++;
            if (start) begin
                check("start_ignored_busy", 512'(busy), 512'(1));
                check("start_ignored_pv", 512'(params_valid), 512'(0));
                start = 1'b0;
            end
            if (xfer) word++;
            phase++;
        end
        s_valid = 1'b0;
        if (n_edges >= 2000) check("load_timeout", 512'(0), 512'(1));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // s_valid in IDLE without start: nothing moves
        s_valid = 1'b1;
        s_data  = 8'hAA;
        check("idle_s_ready", 512'(s_ready), 512'(0));
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 512'(busy), 512'(0));
        check("idle_weights", 512'(weights_flat), 512'(0));
        check("idle_biases", 512'(biases_flat), 512'(0));
        s_valid = 1'b0;

        // back-to-back load of 1..76
        do_load(8'h00, 1'b0, 1'b0, -1, -1, 8'h00, ck_of(8'h00), edges);
        check("full_edges", 512'(edges), 512'(NW + 1));
        check("full_pv", 512'(params_valid), 512'(1));
        check("full_busy", 512'(busy), 512'(0));
        check("full_w_lsb", 512'(weights_flat[7:0]), 512'(1));
        check("full_w_msb", 512'(weights_flat[511:504]), 512'(64));
        check("full_b_lsb", 512'(biases_flat[7:0]), 512'(65));
        check("full_b_msb", 512'(biases_flat[95:88]), 512'(76));
        check("full_weights", 512'(weights_flat), 512'(exp_w(8'h00)));
        check("full_biases", 512'(biases_flat), 512'(exp_b(8'h00)));
        check("full_cksum_err", 512'(cksum_err), 512'(0));
        @(posedge clk); #1;
        check("full_pv_hold", 512'(params_valid), 512'(1));

        // same stream with s_valid alternating 1,0,1,0: NW-1 idle cycles
        do_load(8'h00, 1'b0, 1'b1, -1, -1, 8'h00, ck_of(8'h00), edges);
        check("toggle_edges", 512'(edges), 512'(NW + 1 + NW - 1));
        check("toggle_pv", 512'(params_valid), 512'(1));
        check("toggle_weights", 512'(weights_flat), 512'(exp_w(8'h00)));
        check("toggle_biases", 512'(biases_flat), 512'(exp_b(8'h00)));

        // start re-asserted at word 30 is ignored
        do_load(8'h40, 1'b0, 1'b0, 30, -1, 8'h00, ck_of(8'h40), edges);
        check("restart_edges", 512'(edges), 512'(NW + 1));
        check("restart_pv", 512'(params_valid), 512'(1));
        check("restart_weights", 512'(weights_flat), 512'(exp_w(8'h40)));
        check("restart_biases", 512'(biases_flat), 512'(exp_b(8'h40)));

        // reset at word 40: word 63 still holds the previous load (0x40+64)
        do_load(8'h10, 1'b0, 1'b0, -1, 40, 8'h80, ck_of(8'h10), edges);
        @(posedge clk); #1;
        check("post_abort_busy", 512'(busy), 512'(0));
        check("post_abort_pv", 512'(params_valid), 512'(0));
        do_load(8'h00, 1'b0, 1'b0, -1, -1, 8'h00, ck_of(8'h00), edges);
        check("fresh_edges", 512'(edges), 512'(NW + 1));
        check("fresh_pv", 512'(params_valid), 512'(1));
        check("fresh_weights", 512'(weights_flat), 512'(exp_w(8'h00)));
        check("fresh_biases", 512'(biases_flat), 512'(exp_b(8'h00)));

`ifdef NPU_PARAM_LOADER_CKSUM_EN
        // 76 words of 0x01 XOR to 0x00
        do_load(8'h00, 1'b1, 1'b0, -1, -1, 8'h00, 8'h00, edges);
        check("ck_good_pv", 512'(params_valid), 512'(1));
        check("ck_good_err", 512'(cksum_err), 512'(0));
        do_load(8'h00, 1'b1, 1'b0, -1, -1, 8'h00, 8'h01, edges);
        check("ck_bad_pv", 512'(params_valid), 512'(0));
        check("ck_bad_err", 512'(cksum_err), 512'(1));
        check("ck_bad_busy", 512'(busy), 512'(0));
`else
        check("no_ck_err", 512'(cksum_err), 512'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
